tone_sequencer: RTL
===================

Name: tone_sequencer

Overview:
- Record/playback controller for the tone generator: sits between the keypad scanner's locked key output and the tone decoder's key input.
- Idle mode: passes live keypad notes straight through to the tone decoder.
- Record mode: captures up to DEPTH key presses into an internal note buffer.
- Play mode: sequences the buffer with fixed note/gap timing and optional looping, owning the tone decoder exclusively while playing.

Parameters:
DEPTH, 16, number of note slots (power of two, ≥2)
NOTE_TICKS, 25000000, sys_clk cycles each played note sounds (≥2)
GAP_TICKS, 2500000, silent sys_clk cycles after each played note (≥1)
CNT_W, 25, timer width; must hold max(NOTE_TICKS, GAP_TICKS)-1

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  synchronous active-low reset
key_code  in  4  keypad note code; valid while key_active=1
key_active  in  1  level, high while a key is held
rec_btn  in  1  debounced one-cycle pulse: start/stop record
play_btn  in  1  debounced one-cycle pulse: start playback
stop_btn  in  1  debounced one-cycle pulse: abort record/play
loop_en  in  1  level; 1 = restart playback after last note
tone_code  out  4  note code to tone decoder
tone_en  out  1  1 = tone decoder sounds tone_code; 0 = silence
state  out  2  0 IDLE, 1 RECORD, 2 PLAY_NOTE, 3 PLAY_GAP
note_count  out  log2(DEPTH)+1  notes stored
play_idx  out  log2(DEPTH)  slot currently playing
busy  out  1  state != IDLE

Behaviour:
- All outputs registered. Reset (sys_rst_n=0 at a sys_clk edge): state=IDLE, tone_code=0, tone_en=0, note_count=0, play_idx=0, timer=0, key_active edge detector=0. Buffer contents are not reset and are don't-care until written.
- Live path (IDLE and RECORD): tone_en<=key_active, tone_code<=key_code. One-cycle latency.
- IDLE:
  - Input priority: stop_btn (no effect) > rec_btn > play_btn.
  - rec_btn: note_count<=0, go RECORD.
  - play_btn with note_count=0: stay IDLE.
  - play_btn with note_count>0: play_idx<=0, timer<=0, go PLAY_NOTE.
- RECORD:
  - On each key_active rising edge (registered detector: current=1, previous=0): mem[note_count]<=key_code, note_count+1.
  - The write that makes note_count=DEPTH returns state to IDLE on the same edge.
  - rec_btn or stop_btn: go IDLE; a same-cycle rising edge is still recorded if not full.
  - play_btn ignored.
- PLAY_NOTE:
  - tone_code=mem[play_idx], tone_en=1, valid on the first PLAY_NOTE cycle.
  - timer counts 0..NOTE_TICKS-1; at NOTE_TICKS-1: timer<=0, go PLAY_GAP.
- PLAY_GAP:
  - tone_en=0, tone_code holds.
  - At GAP_TICKS-1: timer<=0.
    - play_idx<note_count-1: play_idx+1, go PLAY_NOTE.
    - Else if loop_en=1 (sampled that cycle): play_idx<=0, go PLAY_NOTE.
    - Else go IDLE.
- In PLAY_*: keypad, rec_btn and play_btn are ignored. stop_btn: go IDLE next edge with tone_en=0, timer<=0; stop wins over a same-cycle timer expiry.
- Timing: one note period = NOTE_TICKS+GAP_TICKS cycles. No dead cycle between a gap and the next note or loop restart.
- note_count and buffer contents survive playback and stop; only a new rec_btn or reset clears note_count.
- Returning to IDLE from PLAY re-enables the live path on the next cycle.

Test Plan (NOTE_TICKS=4, GAP_TICKS=2, DEPTH=4):
1. Reset, then key_active=1 with key_code=5 -> one cycle later tone_en=1, tone_code=5, state=0; release -> tone_en=0 one cycle later.
2. rec_btn, then press keys 3,7,9 (each held 3 cycles, released 2) -> note_count=3, state=1. stop_btn -> state=0, note_count=3.
3. From 2: play_btn with loop_en=0 -> tone_code 3,7,9 each tone_en=1 for exactly 4 cycles followed by 2 cycles tone_en=0. state=0 and busy=0 after cycle 18.
4. From 2: loop_en=1, play_btn, wait 20 cycles -> play_idx wraps 2->0 with no idle cycle. stop_btn mid-note -> next cycle state=0, tone_en=0.
5. rec_btn, press 4 keys -> state=0 on the 4th rising edge, note_count=4; a 5th press is not recorded.
6. Same-cycle rec_btn+play_btn in IDLE -> RECORD, note_count=0. play_btn with note_count=0 -> stays IDLE. Reset mid-PLAY_NOTE -> all outputs return to reset values.

Source files
------------

// File: rtl/tone_sequencer.sv
// ============================================================================
//  Module      : tone_sequencer
//  Description : Record/playback controller between the keypad scanner and
//                the tone decoder (live pass-through, record, timed playback).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tone_sequencer #(
    parameter int DEPTH      = 16,
    parameter int NOTE_TICKS = 25000000,
    parameter int GAP_TICKS  = 2500000,
    parameter int CNT_W      = 25
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [3:0]               key_code,
    input  logic                     key_active,
    input  logic                     rec_btn,
    input  logic                     play_btn,
    input  logic                     stop_btn,
    input  logic                     loop_en,
    output logic [3:0]               tone_code,
    output logic                     tone_en,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   note_count,
    output logic [$clog2(DEPTH)-1:0] play_idx,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_RECORD    = 2'd1;
    localparam logic [1:0] c_PLAY_NOTE = 2'd2;
    localparam logic [1:0] c_PLAY_GAP  = 2'd3;

    localparam logic [CNT_W-1:0] c_NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
    localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] c_TIMER_ONE = CNT_W'(1);
    localparam logic [AW:0]      c_CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]      c_CNT_LAST  = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]      c_CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0]    c_IDX_ONE   = AW'(1);

    logic [1:0]       state_q,      state_d;
    logic [3:0]       tone_code_q,  tone_code_d;
    logic             tone_en_q,    tone_en_d;
    logic [AW:0]      note_count_q, note_count_d;
    logic [AW-1:0]    play_idx_q,   play_idx_d;
    logic [CNT_W-1:0] timer_q,      timer_d;
    logic             busy_q,       busy_d;
    logic             key_prev_q;

    logic [3:0]       mem_q [DEPTH];

    logic             w_key_rise;
    logic             w_wr_en;
    logic [AW:0]      w_idx_next;

    assign w_key_rise = key_active & ~key_prev_q;
    assign w_idx_next = {1'b0, play_idx_q} + c_CNT_ONE;

    always_comb begin
        state_d      = state_q;
        note_count_d = note_count_q;
        play_idx_d   = play_idx_q;
        timer_d      = timer_q;
        w_wr_en      = 1'b0;

        case (state_q)
            c_IDLE: begin
                // stop_btn outranks the other buttons here even though it does nothing
                if (!stop_btn) begin
                    if (rec_btn) begin
                        note_count_d = '0;
                        state_d      = c_RECORD;
                    end else if (play_btn && note_count_q != '0) begin
                        play_idx_d = '0;
                        timer_d    = '0;
                        state_d    = c_PLAY_NOTE;
                    end
                end
            end
            c_RECORD: begin
                if (w_key_rise && note_count_q != c_CNT_FULL) begin
                    w_wr_en      = 1'b1;
                    note_count_d = note_count_q + c_CNT_ONE;
                    if (note_count_q == c_CNT_LAST) begin
                        state_d = c_IDLE;
                    end
                end
                if (rec_btn || stop_btn) begin
                    state_d = c_IDLE;
                end
            end
            c_PLAY_NOTE: begin
                if (stop_btn) begin
                    timer_d = '0;
                    state_d = c_IDLE;
                end else if (timer_q == c_NOTE_LAST) begin
                    timer_d = '0;
                    state_d = c_PLAY_GAP;
                end else begin
                    timer_d = timer_q + c_TIMER_ONE;
                end
            end
            c_PLAY_GAP: begin
                if (stop_btn) begin
                    timer_d = '0;
                    state_d = c_IDLE;
                end else if (timer_q == c_GAP_LAST) begin
                    timer_d = '0;
                    if (w_idx_next < note_count_q) begin
                        play_idx_d = play_idx_q + c_IDX_ONE;
                        state_d    = c_PLAY_NOTE;
                    end else if (loop_en) begin
                        play_idx_d = '0;
                        state_d    = c_PLAY_NOTE;
                    end else begin
                        state_d = c_IDLE;
                    end
                end else begin
                    timer_d = timer_q + c_TIMER_ONE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // Entering a note presents the stored code on the very first note cycle;
    // leaving playback silences for one cycle before the live path resumes.
    always_comb begin
        tone_code_d = tone_code_q;
        tone_en_d   = 1'b0;
        if (state_d == c_PLAY_NOTE) begin
            tone_code_d = mem_q[play_idx_d];
            tone_en_d   = 1'b1;
        end else if (state_q == c_IDLE || state_q == c_RECORD) begin
            tone_code_d = key_code;
            tone_en_d   = key_active;
        end
        busy_d = (state_d != c_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q      <= c_IDLE;
            tone_code_q  <= '0;
            tone_en_q    <= 1'b0;
            note_count_q <= '0;
            play_idx_q   <= '0;
            timer_q      <= '0;
            busy_q       <= 1'b0;
            key_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tone_code_q  <= tone_code_d;
            tone_en_q    <= tone_en_d;
            note_count_q <= note_count_d;
            play_idx_q   <= play_idx_d;
            timer_q      <= timer_d;
            busy_q       <= busy_d;
            key_prev_q   <= key_active;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst_n && w_wr_en) begin
            mem_q[note_count_q[AW-1:0]] <= key_code;
        end
    end

    assign tone_code  = tone_code_q;
    assign tone_en    = tone_en_q;
    assign state      = state_q;
    assign note_count = note_count_q;
    assign play_idx   = play_idx_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire
